// File: rtl/regfiles_pkg.sv
// regfiles_pkg: shared CPU register-file widths and constants
package regfiles_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int REG_COUNT = 2 ** ADDR_W;
  localparam int ZERO_REG = 0;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/regfiles_reg32_en.sv
// reg32_en: data register with synchronous active-low reset and load enable
module reg32_en
  import regfiles_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  data_t d,
  output data_t q
);
  always_ff @(posedge clk)
    if (!rst) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/regfiles.sv
// regfiles: 32x32 register file, two combinational reads, one clocked write, r0 hardwired to zero
module regfiles
  import regfiles_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  addr_t raddr1,
  input  addr_t raddr2,
  input  addr_t waddr,
  input  data_t wdata,
  output data_t rdata1,
  output data_t rdata2
);
  data_t regs [REG_COUNT];
  assign regs[ZERO_REG] = '0;
  for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
    reg32_en u_reg (
      .clk(clk),
      .rst(rst),
      .en (we && waddr == addr_t'(i)),
      .d  (wdata),
      .q  (regs[i])
    );
  end
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
endmodule

// File: tb/tb_regfiles.sv
// tb_regfiles: randomized and directed checks of regfiles against an array model
module tb_regfiles;
  logic clk = 0;
  logic rst, we;
  logic [4:0] raddr1, raddr2, waddr;
  logic [31:0] wdata, rdata1, rdata2;
  logic [31:0] m [32];
  bit armed = 0;
  int checks = 0, passes = 0;

  regfiles dut (
    .clk(clk), .rst(rst), .we(we), .raddr1(raddr1), .raddr2(raddr2),
    .waddr(waddr), .wdata(wdata), .rdata1(rdata1), .rdata2(rdata2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    return a == 0 ? 32'h0 : m[a];
  endfunction

  always @(negedge clk) if (armed) begin
    chk("rdata1", rdata1, model_rd(raddr1));
    chk("rdata2", rdata2, model_rd(raddr2));
  end

  task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    rst = r; we = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
  endtask

  task automatic step;
    @(posedge clk);
    if (!rst) foreach (m[i]) m[i] = 32'h0;
    else if (we && waddr != 0) m[waddr] = wdata;
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    step;
    armed = 1;
    drive(1, 1, 5, 3, 0, 0);
    step;
    drive(1, 0, 0, 0, 5, 4);
    #1 chk("basic_r5", rdata1, 32'd3);
    chk("basic_r4", rdata2, 32'd0);
    drive(1, 0, 11, 10, 11, 5);
    step;
    chk("we0_r11", rdata1, 32'd0);
    chk("we0_r5", rdata2, 32'd3);
    drive(1, 1, 0, 32'hFFFF_FFFF, 0, 0);
    step;
    chk("zero_reg", rdata1, 32'd0);
    drive(1, 1, 7, 1, 7, 7);
    step;
    drive(1, 1, 7, 9, 0, 7);
    #1 chk("same_pre", rdata2, 32'd1);
    step;
    chk("same_post", rdata2, 32'd9);
    drive(0, 1, 8, 32'h55, 8, 7);
    step;
    chk("rstpri_r8", rdata1, 32'd0);
    chk("rstpri_r7", rdata2, 32'd0);
    drive(1, 1, 9, 32'h77, 9, 9);
    step;
    chk("post_rst_wr", rdata1, 32'h77);
    for (int i = 1; i < 32; i++) begin
      drive(1, 1, 5'(i), 32'hA500_0000 | i, 0, 0);
      step;
    end
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1 chk("sweep1", rdata1, i == 0 ? 32'h0 : (32'hA500_0000 | i));
      chk("sweep2", rdata2, (31 - i) == 0 ? 32'h0 : (32'hA500_0000 | (31 - i)));
    end
    drive(0, 0, 0, 0, 0, 0);
    step;
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(i);
      #1 chk("rst_clear1", rdata1, 32'h0);
      chk("rst_clear2", rdata2, 32'h0);
    end
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, 5'($urandom),
            $urandom, 5'($urandom), 5'($urandom));
      step;
    end
    armed = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
